regfile_param: RTL and testbench
================================

// Module: regfile_param
// PURPOSE
//  Parametrised three-port register file: 2 combinational read ports, 1 write port.
//  Successor to the fixed 32x32 file. Adds:
//   - configurable width and depth
//   - optional hardwired zero register
//   - write-to-read bypass
//   - sequenced clear engine on reset and on flush; busy reported while clearing
//  Sits in the datapath between decode (a1/a2) and writeback (a3/wd3/we3).
// PARAMETERS
//  XLEN      32  data width of each register, in bits
//  NREGS     32  number of registers; power of two, >= 2
//  ZERO_REG  1   1: register 0 reads 0 and ignores writes; 0: register 0 is an ordinary register
//  BYPASS    1   1: a same-cycle write is forwarded to matching read ports; 0: no forwarding
//  AW        $clog2(NREGS)  address width (derived; not overridden)
// PORTS
//  clk    in   1     clock; all state updates on the rising edge
//  reset  in   1     synchronous, active-high reset
//  we3    in   1     write enable
//  a1     in   AW    read address, port 1
//  a2     in   AW    read address, port 2
//  a3     in   AW    write address
//  wd3    in   XLEN  write data
//  flush  in   1     request a clear of all registers
//  rd1    out  XLEN  read data, port 1 (combinational)
//  rd2    out  XLEN  read data, port 2 (combinational)
//  busy   out  1     1 while the clear engine is running
// BEHAVIOUR
//  FSM has two states, CLEAR and READY.
//   - reset=1: state<=CLEAR, clr_ptr<=0, rf[0]<=0. Held there for as long as reset is high.
//   - CLEAR, reset=0: each cycle rf[clr_ptr]<=0 and clr_ptr<=clr_ptr+1.
//     When clr_ptr==NREGS-1 is cleared: state<=READY, clr_ptr<=0.
//   - Clear therefore completes NREGS cycles after reset falls (entry 0 is re-cleared on the first cycle).
//   - READY with flush=1: state<=CLEAR, clr_ptr<=0. Clear occupies the next NREGS cycles.
//   - flush while in CLEAR: ignored; the sweep continues without restarting.
//   - reset asserted mid-clear: clr_ptr returns to 0; the sweep restarts after reset falls.
//  Output encoding:
//   - busy = (state==CLEAR). busy is 1 during reset and 1 on the first cycle after reset falls.
//   - While busy: rd1 = rd2 = 0 and we3 is ignored (the write is lost).
//  Writes (state READY only):
//   - if we3=1 and flush=0: rf[a3]<=wd3 on the rising edge.
//   - if ZERO_REG=1 and a3==0: the write is dropped.
//   - flush=1 and we3=1 in the same cycle: flush wins; the write is dropped.
//  Reads (state READY only, combinational, zero cycle latency):
//   - rdN = 0 if ZERO_REG=1 and aN==0.
//   - else, if BYPASS=1 and we3=1 and flush=0 and a3==aN: rdN = wd3 (same-cycle forward).
//   - else rdN = rf[aN].
//   - Both ports may read the same address; both may hit the bypass at once.
//  Storage:
//   - no initial-block preload; contents are defined only by the clear engine.
//   - X on any output after a completed clear is a bug.
// TESTING
//  T1: reset 3 cycles, release.
//      -> busy=1 for exactly NREGS=32 cycles after release; then busy=0 and rd1 = rd2 = 0 for all 32 addresses.
//  T2: READY, we3=1, a3=5, wd3=32'hDEADBEEF, a1=5.
//      -> rd1=32'hDEADBEEF in the same cycle (BYPASS=1); next cycle we3=0 and rd1 still reads 32'hDEADBEEF.
//  T3: we3=1, a3=0, wd3=32'hFFFFFFFF, a1=a2=0.
//      -> rd1 = rd2 = 0 now and after the edge (ZERO_REG=1).
//      Rerun with ZERO_REG=0 -> both read 32'hFFFFFFFF.
//  T4: fill r1..r31 with value i; pulse flush with we3=1, a3=7, wd3=7'h55.
//      -> busy for 32 cycles; r7 is never 7'h55; all registers read 0 after the clear.
//  T5: flush, then assert reset on clear cycle 10 for 2 cycles.
//      -> busy stays 1 and finishes exactly 32 cycles after reset falls; every register is 0.
//  T6: XLEN=16, NREGS=8, BYPASS=0; we3=1, a3=3, wd3=16'h1234, a1=3.
//      -> rd1 keeps the old value (0) that cycle and reads 16'h1234 the next cycle.

Source files
------------

// File: rtl/regfile_param.sv
// regfile_param
//   Parametrised register file with two combinational read ports and one
//   write port. Contents are zeroed by a sequenced clear engine that runs
//   after reset and on a flush request; busy is high while it runs.
//
// Ports
//   clk    in   1     rising-edge clock
//   reset  in   1     synchronous, active-high reset
//   we3    in   1     write enable
//   a1     in   AW    read address, port 1
//   a2     in   AW    read address, port 2
//   a3     in   AW    write address
//   wd3    in   XLEN  write data
//   flush  in   1     request a clear of all registers
//   rd1    out  XLEN  read data, port 1 (combinational)
//   rd2    out  XLEN  read data, port 2 (combinational)
//   busy   out  1     high while the clear engine is running

module regfile_param #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned NREGS    = 32,
   parameter bit          ZERO_REG = 1'b1,
   parameter bit          BYPASS   = 1'b1,
   localparam int unsigned AW      = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            we3,
   input  logic [AW-1:0]   a1,
   input  logic [AW-1:0]   a2,
   input  logic [AW-1:0]   a3,
   input  logic [XLEN-1:0] wd3,
   input  logic            flush,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   output logic            busy
);

   typedef enum logic {
      CLEAR,
      READY
   } state_e;

   localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

   state_e           state_q, state_d;
   logic [AW-1:0]    clr_ptr_q, clr_ptr_d;
   logic [XLEN-1:0]  rf_q [NREGS];

   // Single write request into the array, shared by the clear sweep and
   // the writeback port.
   logic             rf_we_d;
   logic [AW-1:0]    rf_addr_d;
   logic [XLEN-1:0]  rf_data_d;

   // ---------------------------------------------------------------
   // Next-state, clear sweep and write arbitration
   // ---------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      rf_we_d   = 1'b0;
      rf_addr_d = '0;
      rf_data_d = '0;

      unique case (state_q)
         CLEAR: begin
            // One entry per cycle; flush and we3 are ignored here.
            rf_we_d   = 1'b1;
            rf_addr_d = clr_ptr_q;
            rf_data_d = '0;
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == LAST_IDX) begin
               state_d   = READY;
               clr_ptr_d = '0;
            end
         end
         READY: begin
            if (flush) begin
               // Flush takes priority over a coincident write.
               state_d   = CLEAR;
               clr_ptr_d = '0;
            end else if (we3 && !(ZERO_REG && (a3 == '0))) begin
               rf_we_d   = 1'b1;
               rf_addr_d = a3;
               rf_data_d = wd3;
            end
         end
         default: begin
            state_d   = CLEAR;
            clr_ptr_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= CLEAR;
         clr_ptr_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rf_q[0] <= '0;
      end else if (rf_we_d) begin
         rf_q[rf_addr_d] <= rf_data_d;
      end
   end

   // ---------------------------------------------------------------
   // Read ports: zero while clearing, zero register, then bypass, then array
   // ---------------------------------------------------------------
   always_comb begin
      rd1 = '0;
      rd2 = '0;
      if (state_q == READY) begin
         if (ZERO_REG && (a1 == '0)) begin
            rd1 = '0;
         end else if (BYPASS && we3 && !flush && (a3 == a1)) begin
            rd1 = wd3;
         end else begin
            rd1 = rf_q[a1];
         end

         if (ZERO_REG && (a2 == '0)) begin
            rd2 = '0;
         end else if (BYPASS && we3 && !flush && (a3 == a2)) begin
            rd2 = wd3;
         end else begin
            rd2 = rf_q[a2];
         end
      end
   end

   assign busy = (state_q == CLEAR);

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param
//   Drives three register-file configurations from one shared stimulus
//   stream: default (32x32, zero reg, bypass), no zero register, and a
//   16-bit x 8 entry file without bypass. Outputs are compared against
//   constant tables, hand-written sequences and an array-based model.

module tb_regfile_param;

   logic        clk;
   logic        reset;
   logic        we3;
   logic        flush;
   logic [4:0]  a1, a2, a3;
   logic [31:0] wd3;

   logic [31:0] rd1_0, rd2_0, rd1_1, rd2_1;
   logic [15:0] rd1_2, rd2_2;
   logic        busy_0, busy_1, busy_2;

   int unsigned n_pass = 0;
   int unsigned n_tot  = 0;
   bit          chk_en = 1'b0;

   regfile_param u0 (
      .clk(clk), .reset(reset), .we3(we3), .a1(a1), .a2(a2), .a3(a3),
      .wd3(wd3), .flush(flush), .rd1(rd1_0), .rd2(rd2_0), .busy(busy_0)
   );

   regfile_param #(.ZERO_REG(1'b0)) u1 (
      .clk(clk), .reset(reset), .we3(we3), .a1(a1), .a2(a2), .a3(a3),
      .wd3(wd3), .flush(flush), .rd1(rd1_1), .rd2(rd2_1), .busy(busy_1)
   );

   regfile_param #(.XLEN(16), .NREGS(8), .BYPASS(1'b0)) u2 (
      .clk(clk), .reset(reset), .we3(we3), .a1(a1[2:0]), .a2(a2[2:0]),
      .a3(a3[2:0]), .wd3(wd3[15:0]), .flush(flush), .rd1(rd1_2),
      .rd2(rd2_2), .busy(busy_2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------
   // Reference model: per configuration, an array of contents and the
   // number of clear cycles still to run.
   // ---------------------------------------------------------------
   int unsigned nr  [3] = '{32, 32, 8};
   bit          zr  [3] = '{1'b1, 1'b0, 1'b1};
   bit          byp [3] = '{1'b1, 1'b1, 1'b0};
   logic [31:0] msk [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_FFFF};
   logic [31:0] mem [3][32];
   int unsigned bcnt[3] = '{0, 0, 0};

   function automatic logic [31:0] exp_rd(input int d, input logic [4:0] a);
      int unsigned aa = int'(a) % nr[d];
      int unsigned wa = int'(a3) % nr[d];
      if (bcnt[d] != 0)                               return '0;
      if (zr[d] && aa == 0)                           return '0;
      if (byp[d] && we3 && !flush && wa == aa)        return wd3 & msk[d];
      return mem[d][aa];
   endfunction

   task automatic model_edge();
      for (int d = 0; d < 3; d++) begin
         int unsigned wa = int'(a3) % nr[d];
         if (reset) begin
            bcnt[d] = nr[d];
            for (int k = 0; k < 32; k++) mem[d][k] = '0;
         end else if (bcnt[d] != 0) begin
            bcnt[d] = bcnt[d] - 1;
         end else if (flush) begin
            bcnt[d] = nr[d];
            for (int k = 0; k < 32; k++) mem[d][k] = '0;
         end else if (we3 && !(zr[d] && wa == 0)) begin
            mem[d][wa] = wd3 & msk[d];
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h", name, act, exp);
      else
         n_pass++;
   endtask

   // Wait to the falling edge and compare every output against the model.
   task automatic settle();
      @(negedge clk);
      if (chk_en) begin
         chk("m0_rd1",  rd1_0, exp_rd(0, a1));
         chk("m0_rd2",  rd2_0, exp_rd(0, a2));
         chk("m0_busy", {31'b0, busy_0}, {31'b0, bcnt[0] != 0});
         chk("m1_rd1",  rd1_1, exp_rd(1, a1));
         chk("m1_rd2",  rd2_1, exp_rd(1, a2));
         chk("m1_busy", {31'b0, busy_1}, {31'b0, bcnt[1] != 0});
         chk("m2_rd1",  {16'h0, rd1_2}, exp_rd(2, a1));
         chk("m2_rd2",  {16'h0, rd2_2}, exp_rd(2, a2));
         chk("m2_busy", {31'b0, busy_2}, {31'b0, bcnt[2] != 0});
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle_inputs();
      reset = 1'b0; we3 = 1'b0; flush = 1'b0;
      a1 = '0; a2 = '0; a3 = '0; wd3 = '0;
   endtask

   // Counts busy cycles of the default file (bounded) while attempting
   // writes of 0x55 to r7 during the first wr_cycles cycles.
   task automatic run_clear(input string name, input int unsigned wr_cycles);
      int unsigned cnt  = 0;
      bit          done = 1'b0;
      for (int c = 0; c < 100 && !done; c++) begin
         reset = 1'b0; flush = 1'b0;
         we3 = (c < int'(wr_cycles)); a3 = 5'd7; wd3 = 32'h55;
         a1 = 5'd7; a2 = 5'(c);
         settle();
         if (!busy_0) begin
            done = 1'b1;
         end else begin
            cnt++;
            chk({name, "_rd1_busy"}, rd1_0, 32'h0);
         end
         tick();
      end
      chk({name, "_busy_len"}, cnt, 32'd32);
   endtask

   task automatic read_all(input string name);
      for (int a = 0; a < 32; a++) begin
         idle_inputs();
         a1 = 5'(a); a2 = 5'(31 - a);
         settle();
         chk({name, "_rd1_zero"}, rd1_0, 32'h0);
         chk({name, "_rd2_zero"}, rd2_0, 32'h0);
         tick();
      end
   endtask

   typedef struct {
      logic        we;
      logic [4:0]  a1, a2, a3;
      logic [31:0] wd;
      logic [31:0] e_rd1, e_rd2;   // default file
      logic [31:0] e1_rd1;         // file without zero register
   } vec_t;

   vec_t tbl[9];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{1'b1, 5'd5,  5'd6,  5'd5,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0,         32'hDEAD_BEEF};
      tbl[1] = '{1'b0, 5'd5,  5'd5,  5'd0,  32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
      tbl[2] = '{1'b1, 5'd0,  5'd0,  5'd0,  32'hFFFF_FFFF, 32'h0,         32'h0,         32'hFFFF_FFFF};
      tbl[3] = '{1'b0, 5'd0,  5'd0,  5'd0,  32'h0,         32'h0,         32'h0,         32'hFFFF_FFFF};
      tbl[4] = '{1'b1, 5'd9,  5'd9,  5'd9,  32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678};
      tbl[5] = '{1'b1, 5'd9,  5'd5,  5'd9,  32'h0BAD_F00D, 32'h0BAD_F00D, 32'hDEAD_BEEF, 32'h0BAD_F00D};
      tbl[6] = '{1'b0, 5'd9,  5'd31, 5'd0,  32'h0,         32'h0BAD_F00D, 32'h0,         32'h0BAD_F00D};
      tbl[7] = '{1'b1, 5'd31, 5'd9,  5'd31, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0BAD_F00D, 32'hA5A5_A5A5};
      tbl[8] = '{1'b0, 5'd31, 5'd0,  5'd0,  32'h0,         32'hA5A5_A5A5, 32'h0,         32'hA5A5_A5A5};

      // T1: reset for 3 cycles, then the initial clear
      idle_inputs();
      reset = 1'b1;
      tick();
      chk_en = 1'b1;
      settle();
      chk("reset_busy", {31'b0, busy_0}, 32'd1);
      chk("reset_rd1",  rd1_0, 32'h0);
      chk("reset_rd2",  rd2_0, 32'h0);
      tick();
      tick();
      reset = 1'b0;
      run_clear("t1", 0);
      read_all("t1");

      // T2/T3 and general reads/writes from the vector table
      for (int i = 0; i < 9; i++) begin
         idle_inputs();
         we3 = tbl[i].we; a1 = tbl[i].a1; a2 = tbl[i].a2;
         a3  = tbl[i].a3; wd3 = tbl[i].wd;
         settle();
         chk($sformatf("tbl%0d_rd1", i),    rd1_0, tbl[i].e_rd1);
         chk($sformatf("tbl%0d_rd2", i),    rd2_0, tbl[i].e_rd2);
         chk($sformatf("tbl%0d_nz_rd1", i), rd1_1, tbl[i].e1_rd1);
         tick();
      end

      // T6: 16x8 file without bypass sees the write only on the next cycle
      idle_inputs();
      we3 = 1'b1; a3 = 5'd3; wd3 = 32'h0000_1234; a1 = 5'd3; a2 = 5'd3;
      settle();
      chk("t6_nobyp_same", {16'h0, rd1_2}, 32'h0);
      chk("t6_byp_same",   rd1_0, 32'h0000_1234);
      tick();
      we3 = 1'b0;
      settle();
      chk("t6_nobyp_next", {16'h0, rd1_2}, 32'h0000_1234);
      tick();

      // T4: fill r1..r31, flush with a coincident write to r7
      for (int i = 1; i < 32; i++) begin
         idle_inputs();
         we3 = 1'b1; a3 = 5'(i); wd3 = i; a1 = 5'(i); a2 = 5'(i - 1);
         settle();
         tick();
      end
      idle_inputs();
      a1 = 5'd7; a2 = 5'd31;
      settle();
      chk("t4_r7",  rd1_0, 32'd7);
      chk("t4_r31", rd2_0, 32'd31);
      tick();
      we3 = 1'b1; a3 = 5'd7; wd3 = 32'h55; flush = 1'b1; a1 = 5'd7;
      settle();
      chk("t4_flush_no_byp", rd1_0, 32'd7);
      tick();
      run_clear("t4", 31);
      read_all("t4");

      // T5: flush, reset on clear cycle 10 for two cycles
      idle_inputs();
      we3 = 1'b1; a3 = 5'd4; wd3 = 32'h4444; tick();
      idle_inputs();
      flush = 1'b1;
      settle();
      tick();
      for (int c = 0; c < 9; c++) begin
         idle_inputs();
         flush = (c == 3);
         settle();
         chk("t5_busy_mid", {31'b0, busy_0}, 32'd1);
         tick();
      end
      idle_inputs();
      reset = 1'b1;
      settle();
      tick();
      settle();
      chk("t5_busy_reset", {31'b0, busy_0}, 32'd1);
      tick();
      reset = 1'b0;
      run_clear("t5", 0);
      read_all("t5");

      // Randomised traffic against the model
      for (int i = 0; i < 600; i++) begin
         reset = ($urandom_range(0, 199) == 0);
         flush = ($urandom_range(0, 29) == 0);
         we3   = ($urandom_range(0, 3) != 0);
         a3    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         a1    = ($urandom_range(0, 2) == 0) ? a3 : 5'($urandom);
         a2    = ($urandom_range(0, 2) == 0) ? a3 : 5'($urandom);
         wd3   = $urandom;
         settle();
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
